// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch requester with a 2-entry decode skid buffer
//               and execute redirects. Optional macro IFU_PC_WRAP_EN confines
//               the fetch address to the IMEM_WORDS-deep memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

`ifdef IFU_PC_WRAP_EN
  localparam logic [31:0] C_PC_MASK = 32'(IMEM_WORDS * 4) - 32'd1;
`else
  localparam logic [31:0] C_PC_MASK = 32'hFFFF_FFFF;
`endif

  if ((IMEM_WORDS < 1) || ((IMEM_WORDS & (IMEM_WORDS - 1)) != 0) ||
      (RESET_PC[1:0] != 2'b00)) begin : g_param_check
    $error("instr_fetch_unit: IMEM_WORDS must be a power of 2 and RESET_PC word aligned");
  end

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_pc_d    [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [1:0]  count_q, count_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  push_slot;
  logic [31:0] pc_inc;
  logic [31:0] redir_target;

  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = (count_q != 2'd0);
  assign if_pc_o     = fifo_pc_q[0];
  assign if_instr_o  = fifo_instr_q[0];

  assign pop          = if_valid_o && if_ready_i;
  assign push         = inflight_q;
  assign pc_inc       = (fetch_pc_q + 32'd4) & C_PC_MASK;
  assign redir_target = {redirect_pc_i[31:2], 2'b00} & C_PC_MASK;

  // Buffered entries plus the outstanding return, net of this cycle's pop,
  // must leave room for the instruction about to be requested.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = !redirect_valid_i && (occupancy <= 3'd1);
  assign push_slot = count_q - {1'b0, pop};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;

    if (redirect_valid_i) begin
      fetch_pc_d = redir_target;
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        fifo_pc_d[0]    = fifo_pc_q[1];
        fifo_instr_d[0] = fifo_instr_q[1];
      end
      if (push) begin
        fifo_pc_d[push_slot[0]]    = inflight_pc_q;
        fifo_instr_d[push_slot[0]] = imem_instr_i;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_pc_q   <= '0;
      count_q         <= 2'd0;
      fifo_pc_q[0]    <= '0;
      fifo_pc_q[1]    <= '0;
      fifo_instr_q[0] <= '0;
      fifo_instr_q[1] <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit (table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];

`ifdef IFU_PC_WRAP_EN
  localparam logic [31:0] N_AFTER_7C = 32'h0000_0000;
  localparam logic [31:0] TOP_PC     = 32'h0000_007C;
`else
  localparam logic [31:0] N_AFTER_7C = 32'h0000_0080;
  localparam logic [31:0] TOP_PC     = 32'hFFFF_FFFC;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return 32'd100 + (a >> 2);
  endfunction

  // Memory with a registered read port: data for address of cycle t shows in t+1.
  always @(posedge clk) imem_instr <= mem_of(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] eaddr);
    chk({tag, " valid"}, {31'b0, if_valid}, {31'b0, ev});
    if (ev) begin
      chk({tag, " pc"}, if_pc, epc);
      chk({tag, " instr"}, if_instr, mem_of(epc));
    end
    chk({tag, " imem_addr"}, imem_addr, eaddr);
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    rst            = r;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every decode transfer must match the next expected pc.
  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL xfer_unexpected: got pc %h expected no transfer", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("xfer pc", if_pc, e);
        chk("xfer instr", if_instr, mem_of(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 32'h04};
    tbl[2]  = '{1'b1, 1'b1, 32'h00, 32'h08};
    tbl[3]  = '{1'b1, 1'b1, 32'h04, 32'h0C};
    tbl[4]  = '{1'b1, 1'b1, 32'h08, 32'h10};
    tbl[5]  = '{1'b1, 1'b1, 32'h0C, 32'h14};
    tbl[6]  = '{1'b1, 1'b1, 32'h10, 32'h18};
    tbl[7]  = '{1'b1, 1'b1, 32'h14, 32'h1C};
    tbl[8]  = '{1'b0, 1'b1, 32'h18, 32'h20};
    tbl[9]  = '{1'b0, 1'b1, 32'h18, 32'h20};
    tbl[10] = '{1'b0, 1'b1, 32'h18, 32'h20};
    tbl[11] = '{1'b0, 1'b1, 32'h18, 32'h20};
    tbl[12] = '{1'b1, 1'b1, 32'h18, 32'h20};
    tbl[13] = '{1'b1, 1'b1, 32'h1C, 32'h24};
    tbl[14] = '{1'b1, 1'b1, 32'h20, 32'h28};
    tbl[15] = '{1'b1, 1'b1, 32'h24, 32'h2C};

    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_o("reset", 1'b0, 32'h0, 32'h0);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset if_instr", if_instr, 32'h0);
    nxt();

    // Streaming from reset, then a 4-cycle decode stall.
    for (int a = 0; a <= 40; a += 4) exp_q.push_back(32'(a));
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, tbl[i].rdy, 1'b0, 32'h0);
      expect_o($sformatf("stream c%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
      nxt();
    end

    // Redirect to 0x40 while pc 0x28 is handed over.
    cyc(1'b0, 1'b1, 1'b1, 32'h40); expect_o("redir c16", 1'b1, 32'h28, 32'h30); nxt();
    chk("queue drained before redirect", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir t+1", 1'b0, 32'h0, 32'h40); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir t+2", 1'b0, 32'h0, 32'h44); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir t+3", 1'b1, 32'h40, 32'h48); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir t+4", 1'b1, 32'h44, 32'h4C); nxt();

    // Unaligned redirect coinciding with a handshake on pc 0x48.
    cyc(1'b0, 1'b1, 1'b1, 32'h43); expect_o("redir43 t", 1'b1, 32'h48, 32'h50); nxt();
    chk("queue drained at redirect43", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir43 t+1", 1'b0, 32'h0, 32'h40); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir43 t+2", 1'b0, 32'h0, 32'h44); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("redir43 t+3", 1'b1, 32'h40, 32'h48); nxt();

    // Fill the buffer, then reset mid-operation.
    cyc(1'b0, 1'b0, 1'b0, 32'h0); expect_o("fill 1", 1'b1, 32'h44, 32'h4C); nxt();
    cyc(1'b1, 1'b0, 1'b0, 32'h0); expect_o("fill 2", 1'b1, 32'h44, 32'h4C); nxt();
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("rst r0", 1'b0, 32'h0, 32'h0); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("rst r1", 1'b0, 32'h0, 32'h4); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("rst r2", 1'b1, 32'h0, 32'h8); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("rst r3", 1'b1, 32'h4, 32'hC); nxt();

    // Fetch across the end of a 32-word memory.
    cyc(1'b0, 1'b1, 1'b1, 32'h78); expect_o("wrap redir", 1'b1, 32'h8, 32'h10); nxt();
    chk("queue drained at redirect78", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h78); exp_q.push_back(32'h7C); exp_q.push_back(N_AFTER_7C);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("wrap t+1", 1'b0, 32'h0, 32'h78); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("wrap t+2", 1'b0, 32'h0, 32'h7C); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("wrap t+3", 1'b1, 32'h78, N_AFTER_7C); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    expect_o("wrap t+4", 1'b1, 32'h7C, N_AFTER_7C + 32'h4); nxt();

    // Back-to-back redirects: only the second target is delivered.
    cyc(1'b0, 1'b1, 1'b1, 32'h10);
    expect_o("b2b first", 1'b1, N_AFTER_7C, N_AFTER_7C + 32'h8); nxt();
    chk("queue drained at b2b", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h20); exp_q.push_back(32'h24);
    cyc(1'b0, 1'b1, 1'b1, 32'h21); expect_o("b2b second", 1'b0, 32'h0, 32'h10); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("b2b t+1", 1'b0, 32'h0, 32'h20); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("b2b t+2", 1'b0, 32'h0, 32'h24); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("b2b t+3", 1'b1, 32'h20, 32'h28); nxt();

    // Top of the address space.
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF); expect_o("top redir", 1'b1, 32'h24, 32'h2C); nxt();
    chk("queue drained at top", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(TOP_PC); exp_q.push_back(32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("top t+1", 1'b0, 32'h0, TOP_PC); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("top t+2", 1'b0, 32'h0, 32'h0); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("top t+3", 1'b1, TOP_PC, 32'h4); nxt();
    cyc(1'b0, 1'b1, 1'b0, 32'h0); expect_o("top t+4", 1'b1, 32'h0, 32'h8); nxt();
    cyc(1'b0, 1'b0, 1'b0, 32'h0); nxt();
    chk("queue empty at end", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
